death_anim_fetch: RTL and testbench

Initiator side of the sprite frame-ROM read interface.
- Sequences a 4-frame death animation: which ROM is selected, and for how many video frames each one is shown.
- Generates the per-pixel read_address into the selected 32x32 sprite ROM from the VGA draw coordinates.
- Takes back the ROM's registered 24-bit colour, applies colour-key transparency, and produces a pipelined pixel/enable pair for the colour mapper.

---
 rtl/death_anim_fetch.sv | 137 +++++++++++++
 tb/tb_death_anim_fetch.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/death_anim_fetch.sv
// rtl/death_anim_fetch.sv - death animation frame sequencer and sprite ROM fetch pipeline
// Optional build macro DEATH_ANIM_LOOP_EN: loop the animation forever instead of one-shot.
module death_anim_fetch #(
  parameter int          SPR_W        = 32,
  parameter int          SPR_H        = 32,
  parameter int          NUM_FRAMES   = 4,
  parameter int          HOLD_FRAMES  = 8,
  parameter logic [23:0] TRANSP_COLOR = 24'hfffed2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        start,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [18:0] read_address,
  output logic [1:0]  frame_sel,
  input  logic [23:0] rom_data,
  output logic        pixel_on,
  output logic [23:0] pixel_rgb,
  output logic        busy,
  output logic        done
);

  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);
  localparam logic [1:0]    FRAME_LAST = 2'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, FINISH} state_t;

  state_t        state, state_n;
  logic [1:0]    frame_sel_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [9:0]    pos_x, pos_y;
  logic          frame_clk_d, tick;
  logic          in_box, in_box_d;
  logic [10:0]   x_end, y_end;
  logic [9:0]    rel_x, rel_y;
`ifdef DEATH_ANIM_LOOP_EN
  logic          wrap_n, wrap_q;
`endif

  assign tick = frame_clk & ~frame_clk_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      frame_sel   <= 2'd0;
      hold_cnt    <= '0;
      pos_x       <= 10'd0;
      pos_y       <= 10'd0;
      frame_clk_d <= 1'b0;
      in_box_d    <= 1'b0;
      pixel_on    <= 1'b0;
      pixel_rgb   <= 24'd0;
`ifdef DEATH_ANIM_LOOP_EN
      wrap_q      <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      frame_sel   <= frame_sel_n;
      hold_cnt    <= hold_cnt_n;
      frame_clk_d <= frame_clk;
      if (state == IDLE && start) begin
        pos_x <= sprite_x;
        pos_y <= sprite_y;
      end
      in_box_d  <= in_box & busy;
      pixel_on  <= in_box_d && (rom_data != TRANSP_COLOR);
      pixel_rgb <= (in_box_d && (rom_data != TRANSP_COLOR)) ? rom_data : 24'd0;
`ifdef DEATH_ANIM_LOOP_EN
      wrap_q    <= wrap_n;
`endif
    end
  end

  // frame_sel only moves on a vsync tick, so the selected ROM never changes mid-line
  always_comb begin
    state_n     = state;
    frame_sel_n = frame_sel;
    hold_cnt_n  = hold_cnt;
`ifdef DEATH_ANIM_LOOP_EN
    wrap_n      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n     = PLAY;
          frame_sel_n = 2'd0;
          hold_cnt_n  = '0;
        end
      end
      PLAY: begin
        if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt_n = '0;
            if (frame_sel == FRAME_LAST) begin
`ifdef DEATH_ANIM_LOOP_EN
              frame_sel_n = 2'd0;
              wrap_n      = 1'b1;
`else
              state_n     = FINISH;
`endif
            end else begin
              frame_sel_n = frame_sel + 2'd1;
            end
          end else begin
            hold_cnt_n = hold_cnt + HW'(1);
          end
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == PLAY);
`ifdef DEATH_ANIM_LOOP_EN
    done = wrap_q;
`else
    done = (state == FINISH);
`endif
  end

  // 11-bit box limits keep sprites near the right/bottom edge from wrapping
  assign x_end  = {1'b0, pos_x} + 11'(SPR_W);
  assign y_end  = {1'b0, pos_y} + 11'(SPR_H);
  assign in_box = (DrawX >= pos_x) && ({1'b0, DrawX} < x_end) &&
                  (DrawY >= pos_y) && ({1'b0, DrawY} < y_end);
  assign rel_x  = DrawX - pos_x;
  assign rel_y  = DrawY - pos_y;
  assign read_address = in_box ? (19'(rel_y) * 19'(SPR_W) + 19'(rel_x)) : 19'd0;

endmodule

// File: tb/tb_death_anim_fetch.sv
// tb/tb_death_anim_fetch.sv - directed self-checking bench for death_anim_fetch
module tb_death_anim_fetch;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  sprite_x = '0, sprite_y = '0, DrawX = '0, DrawY = '0;
  logic [18:0] read_address;
  logic [1:0]  frame_sel;
  logic [23:0] rom_data = '0;
  logic        pixel_on, busy, done;
  logic [23:0] pixel_rgb;

  int checks = 0;
  int errors = 0;

`ifdef DEATH_ANIM_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  death_anim_fetch dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .DrawX(DrawX), .DrawY(DrawY),
    .read_address(read_address), .frame_sel(frame_sel), .rom_data(rom_data),
    .pixel_on(pixel_on), .pixel_rgb(pixel_rgb), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic frame_edge(input int high_cycles);
    frame_clk = 1'b1;
    cyc(high_cycles);
    frame_clk = 1'b0;
    cyc(2);
  endtask

  initial begin
    cyc(3);
    Reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame_sel", frame_sel, 0);
    check("rst_pixel_on", pixel_on, 0);

    rom_data = 24'hd54014;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      check("idle_pixel_on", pixel_on, 0);
      check("idle_pixel_rgb", pixel_rgb, 0);
      check("idle_busy", busy, 0);
      check("idle_addr", read_address, 0);
    end

    sprite_x = 10'd100;
    sprite_y = 10'd50;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_frame_sel", frame_sel, 0);
    DrawX = 10'd105;
    DrawY = 10'd52;
    #1;
    check("addr_69", read_address, 69);
    cyc(1);
    check("lat1_pixel_on", pixel_on, 0);
    cyc(1);
    check("lat2_pixel_on", pixel_on, 1);
    check("lat2_pixel_rgb", pixel_rgb, 24'hd54014);

    rom_data = 24'hfffed2;
    cyc(1);
    check("transp_pixel_on", pixel_on, 0);
    check("transp_pixel_rgb", pixel_rgb, 0);

    rom_data = 24'hd54014;
    DrawX = 10'd131;
    #1;
    check("addr_edge_in", read_address, 95);
    DrawX = 10'd132;
    #1;
    check("addr_outside", read_address, 0);
    cyc(2);
    check("outside_pixel_on", pixel_on, 0);
    check("outside_pixel_rgb", pixel_rgb, 0);

    frame_edge(20);
    for (int i = 0; i < 6; i++) frame_edge(1);
    check("edge7_frame_sel", frame_sel, 0);
    frame_edge(1);
    check("edge8_frame_sel", frame_sel, 1);

    sprite_x = 10'd0;
    sprite_y = 10'd0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("play_start_frame_sel", frame_sel, 1);
    check("play_start_busy", busy, 1);
    DrawX = 10'd105;
    DrawY = 10'd52;
    #1;
    check("play_start_addr", read_address, 69);
    for (int i = 0; i < 7; i++) frame_edge(1);
    check("edge15_frame_sel", frame_sel, 1);
    frame_edge(1);
    check("edge16_frame_sel", frame_sel, 2);

    for (int i = 0; i < 15; i++) frame_edge(1);
    check("edge31_frame_sel", frame_sel, 3);
    check("edge31_busy", busy, 1);
    check("edge31_done", done, 0);
    frame_clk = 1'b1;
    cyc(1);
    check("edge32_done", done, 1);
    check("edge32_busy", busy, LOOP ? 1 : 0);
    check("edge32_frame_sel", frame_sel, LOOP ? 0 : 3);
    cyc(1);
    check("after_done", done, 0);
    check("after_busy", busy, LOOP ? 1 : 0);
    frame_clk = 1'b0;
    cyc(2);
    check("idle_frame_sel_hold", frame_sel, LOOP ? 0 : 3);

    // start and a frame_clk edge land together; the tick must not count in IDLE
    sprite_x = 10'd1010;
    sprite_y = 10'd0;
    start = 1'b1;
    frame_clk = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    frame_clk = 1'b0;
    cyc(2);
    check("restart_busy", busy, 1);
    DrawX = 10'd1023;
    DrawY = 10'd3;
    #1;
    check("addr_right_edge", read_address, LOOP ? 0 : 109);
    DrawX = 10'd1009;
    #1;
    check("addr_left_of_box", read_address, 0);

    for (int i = 0; i < (LOOP ? 14 : 15); i++) frame_edge(1);
    check("pre_rst_frame_sel_1", frame_sel, 1);
    frame_edge(1);
    check("pre_rst_frame_sel_2", frame_sel, 2);
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_frame_sel", frame_sel, 0);
    check("abort_done", done, 0);
    cyc(1);
    check("abort_done_later", done, 0);
    check("abort_pixel_on", pixel_on, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
